// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO register pair for the E stage.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, op[3:0], a, b : operation issued from E (accepted only when idle)
//   cancel                  : abort an in-flight multi-cycle op without commit
//   busy                    : multi-cycle op in flight (stall request to hazard unit)
//   done                    : one-cycle pulse after HI/LO written by a multi-cycle op
//   hi, lo                  : architectural HI/LO registers
module md_unit_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT) + 1;
  localparam int unsigned W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  state_t           state, state_nx;
  acc_t             mode, mode_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [W2-1:0]    pend, pend_nx;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             done_nx;

  // Products: sign/zero extend to 2*WIDTH so the truncated product is exact.
  logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide via magnitudes; most-negative / -1 falls out as lo=a, hi=0.
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, qs, rs, qu, ru;
  logic [W2-1:0]    div_s_res, div_u_res;
  assign a_neg     = a[WIDTH-1];
  assign b_neg     = b[WIDTH-1];
  assign div_zero  = (b == '0);
  assign a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
  assign q_mag     = a_mag / b_mag;
  assign r_mag     = a_mag % b_mag;
  assign qs        = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
  assign rs        = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
  assign qu        = a / b;
  assign ru        = a % b;
  assign div_s_res = div_zero ? {a, {WIDTH{1'b1}}} : {rs, qs};
  assign div_u_res = div_zero ? {a, {WIDTH{1'b1}}} : {ru, qu};

  // Registers: state, counter, pending result, HI/LO and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mode  <= ACC_NONE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      mode  <= mode_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      busy  <= (state_nx == BUSY);
      done  <= done_nx;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, commit at count 1.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    cnt_nx   = cnt;
    pend_nx  = pend;
    hi_nx    = hi;
    lo_nx    = lo;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (in_valid && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_nx = BUSY;
              cnt_nx   = CW'(MUL_LAT);
              pend_nx  = (op == OP_MULTU || op == OP_MADDU || op == OP_MSUBU) ? prod_u : prod_s;
              mode_nx  = (op == OP_MADD || op == OP_MADDU) ? ACC_ADD :
                         (op == OP_MSUB || op == OP_MSUBU) ? ACC_SUB : ACC_NONE;
            end
            OP_DIV, OP_DIVU: begin
              state_nx = BUSY;
              cnt_nx   = CW'(DIV_LAT);
              pend_nx  = (op == OP_DIV) ? div_s_res : div_u_res;
              mode_nx  = ACC_NONE;
            end
            OP_MTHI: hi_nx = a;
            OP_MTLO: lo_nx = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cancel) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
          // Accumulate against HI/LO as they stand at commit.
          case (mode)
            ACC_ADD: {hi_nx, lo_nx} = {hi, lo} + pend;
            ACC_SUB: {hi_nx, lo_nx} = {hi, lo} - pend;
            default: {hi_nx, lo_nx} = pend;
          endcase
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
